// File: rtl/pc_gen_unit.sv
// Program-counter generator for the fetch stage.
// Holds the PC, issues fetch requests over a valid/ready handshake and
// applies prioritised redirects (exception > mret > branch). A redirect that
// arrives while a request is stuck waiting for ready is buffered and applied
// when that request is accepted; the accepted request is then flagged stale.
module pc_gen_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INC          = 4,
  parameter int              ALIGN_BITS   = 2,
  parameter int              BOOT_DELAY   = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_clk_en,
  input  logic            i_stall,
  input  logic            i_br_taken,
  input  logic [XLEN-1:0] i_br_target,
  input  logic            i_exc,
  input  logic [XLEN-1:0] i_exc_vec,
  input  logic            i_mret,
  input  logic [XLEN-1:0] i_mepc,
  input  logic            i_req_ready,
  output logic            o_req_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus,
  output logic            o_req_stale,
  output logic            o_redir_pend
);

  localparam int              CNT_W      = (BOOT_DELAY < 2) ? 1 : $clog2(BOOT_DELAY + 1);
  localparam logic [XLEN-1:0] INC_V      = XLEN'(INC);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~((XLEN'(1) << ALIGN_BITS) - XLEN'(1));
  localparam logic [CNT_W-1:0] BOOT_INIT = CNT_W'(BOOT_DELAY);

  typedef enum logic [1:0] {ST_BOOT, ST_IDLE, ST_REQ} state_t;

  localparam state_t RESET_STATE = (BOOT_DELAY == 0) ? ST_IDLE : ST_BOOT;

  state_t           state_reg, state_next;
  logic [XLEN-1:0]  pc_reg, pc_next;
  logic             pend_reg, pend_next;
  logic [XLEN-1:0]  pend_tgt_reg, pend_tgt_next;
  logic             pend_exc_reg, pend_exc_next;
  logic [CNT_W-1:0] boot_cnt_reg, boot_cnt_next;

  logic            redir_strobe;
  logic            redir_now;
  logic            accept;
  logic [XLEN-1:0] redir_target;

  // Redirect source selection with fixed priority, target aligned down.
  always_comb begin
    redir_strobe = i_exc | i_mret | i_br_taken;
    redir_now    = i_clk_en & redir_strobe;
    accept       = (state_reg == ST_REQ) & i_req_ready;
    if (i_exc)
      redir_target = i_exc_vec & ALIGN_MASK;
    else if (i_mret)
      redir_target = i_mepc & ALIGN_MASK;
    else
      redir_target = i_br_target & ALIGN_MASK;
  end

  // State registers; everything holds when the clock enable is low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= RESET_STATE;
      pc_reg       <= RESET_VECTOR;
      pend_reg     <= 1'b0;
      pend_tgt_reg <= '0;
      pend_exc_reg <= 1'b0;
      boot_cnt_reg <= BOOT_INIT;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      pend_reg     <= pend_next;
      pend_tgt_reg <= pend_tgt_next;
      pend_exc_reg <= pend_exc_next;
      boot_cnt_reg <= boot_cnt_next;
    end
  end

  // Next-state logic: boot countdown, idle redirect/launch, request handshake.
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    pend_next     = pend_reg;
    pend_tgt_next = pend_tgt_reg;
    pend_exc_next = pend_exc_reg;
    boot_cnt_next = boot_cnt_reg;
    if (i_clk_en) begin
      case (state_reg)
        ST_BOOT: begin
          // No request is outstanding, so a redirect lands in the PC directly.
          if (redir_strobe)
            pc_next = redir_target;
          if (boot_cnt_reg != '0)
            boot_cnt_next = boot_cnt_reg - CNT_W'(1);
          if (boot_cnt_reg <= CNT_W'(1))
            state_next = ST_IDLE;
        end
        ST_IDLE: begin
          if (redir_strobe)
            pc_next = redir_target;
          if (!i_stall)
            state_next = ST_REQ;
        end
        ST_REQ: begin
          if (accept) begin
            // A same-cycle redirect supersedes anything buffered.
            if (redir_strobe)
              pc_next = redir_target;
            else if (pend_reg)
              pc_next = pend_tgt_reg;
            else
              pc_next = pc_reg + INC_V;
            pend_next  = 1'b0;
            state_next = i_stall ? ST_IDLE : ST_REQ;
          end else if (redir_strobe) begin
            // A buffered exception outranks a later mret or branch.
            if (!(pend_reg && pend_exc_reg && !i_exc)) begin
              pend_tgt_next = redir_target;
              pend_exc_next = i_exc;
            end
            pend_next = 1'b1;
          end
        end
        default: state_next = RESET_STATE;
      endcase
    end
  end

  // Outputs: valid comes only from the state; stale marks a wrong-path accept.
  always_comb begin
    o_req_valid  = (state_reg == ST_REQ);
    o_pc         = pc_reg;
    o_pc_plus    = pc_reg + INC_V;
    o_redir_pend = pend_reg;
    o_req_stale  = (state_reg == ST_REQ) & (pend_reg | redir_now);
  end

endmodule

// File: tb/tb_pc_gen_unit.sv
// Self-checking bench for pc_gen_unit: directed scenarios plus a randomized
// run, all compared against a behavioural model of the fetch PC rules.
module tb_pc_gen_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_en, stall, br_taken, exc, mret, req_ready;
  logic [31:0] br_target, exc_vec, mepc;
  logic        req_valid, req_stale, redir_pend;
  logic [31:0] pc, pc_plus;

  int total  = 0;
  int passed = 0;

  // Behavioural model state
  localparam int M_BOOT = 0, M_IDLE = 1, M_REQ = 2;
  int          m_mode;
  int          m_boot;
  logic [31:0] m_pc;
  bit          m_pend;
  bit          m_pexc;
  logic [31:0] m_ptgt;

  pc_gen_unit #(
    .XLEN(32), .RESET_VECTOR(32'h0), .INC(4), .ALIGN_BITS(2), .BOOT_DELAY(2)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clk_en(clk_en), .i_stall(stall),
    .i_br_taken(br_taken), .i_br_target(br_target),
    .i_exc(exc), .i_exc_vec(exc_vec), .i_mret(mret), .i_mepc(mepc),
    .i_req_ready(req_ready), .o_req_valid(req_valid), .o_pc(pc),
    .o_pc_plus(pc_plus), .o_req_stale(req_stale), .o_redir_pend(redir_pend)
  );

  always #5 clk = ~clk;

  task model_reset();
    m_mode = M_BOOT;
    m_boot = 2;
    m_pc   = 32'h0;
    m_pend = 0;
    m_pexc = 0;
    m_ptgt = 32'h0;
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task model_edge();
    bit          redir;
    logic [31:0] tgt;
    if (!rst_n || !clk_en) return;
    redir = br_taken || exc || mret;
    tgt   = (exc ? exc_vec : (mret ? mepc : br_target)) & 32'hFFFF_FFFC;
    if (m_mode == M_BOOT) begin
      if (redir) m_pc = tgt;
      m_boot = m_boot - 1;
      if (m_boot == 0) m_mode = M_IDLE;
    end else if (m_mode == M_IDLE) begin
      if (redir) m_pc = tgt;
      if (!stall) m_mode = M_REQ;
    end else begin
      if (req_ready) begin
        m_pc   = redir ? tgt : (m_pend ? m_ptgt : m_pc + 32'd4);
        m_pend = 0;
        m_mode = stall ? M_IDLE : M_REQ;
      end else if (redir) begin
        if (!(m_pend && m_pexc && !exc)) begin
          m_ptgt = tgt;
          m_pexc = exc;
        end
        m_pend = 1;
      end
    end
  endtask

  task tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task clear_strobes();
    br_taken = 0; exc = 0; mret = 0;
  endtask

  task test_reset();
    rst_n = 0; clk_en = 1; stall = 0; req_ready = 0;
    clear_strobes();
    br_target = 0; exc_vec = 0; mepc = 0;
    #12;
    total++; if (req_valid !== 1'b0) $display("FAIL reset_valid got=%0b want=0", req_valid); else passed++;
    total++; if (pc !== 32'h0) $display("FAIL reset_pc got=%h want=00000000", pc); else passed++;
    total++; if (pc_plus !== 32'h4) $display("FAIL reset_pc_plus got=%h want=00000004", pc_plus); else passed++;
    total++; if (redir_pend !== 1'b0) $display("FAIL reset_pend got=%0b want=0", redir_pend); else passed++;
    total++; if (req_stale !== 1'b0) $display("FAIL reset_stale got=%0b want=0", req_stale); else passed++;
    rst_n = 1;
    model_reset();
  endtask

  // Boot delay then sequential fetch: first request appears after boot+idle.
  task test_boot_seq();
    logic [31:0] exp_pc;
    bit          exp_v;
    req_ready = 1; stall = 0;
    for (int c = 0; c < 7; c++) begin
      #1;
      exp_v  = (c >= 3);
      exp_pc = (c >= 3) ? 32'((c - 3) * 4) : 32'h0;
      total++; if (req_valid !== exp_v) $display("FAIL boot_valid c=%0d got=%0b want=%0b", c, req_valid, exp_v); else passed++;
      total++; if (pc !== exp_pc) $display("FAIL boot_pc c=%0d got=%h want=%h", c, pc, exp_pc); else passed++;
      $display("boot cycle %0d valid=%0b pc=%h", c, req_valid, pc);
      tick();
    end
  endtask

  task test_hold();
    req_ready = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (pc !== 32'h10 || req_valid !== 1'b1) $display("FAIL hold c=%0d got pc=%h v=%0b want pc=00000010 v=1", c, pc, req_valid); else passed++;
      tick();
    end
    req_ready = 1;
    tick();
    total++; if (pc !== 32'h14) $display("FAIL hold_release got=%h want=00000014", pc); else passed++;
    $display("hold released pc=%h", pc);
    tick(); tick(); tick();
  endtask

  task test_buffered_branch();
    total++; if (pc !== 32'h20) $display("FAIL bb_start got=%h want=00000020", pc); else passed++;
    req_ready = 0; br_taken = 1; br_target = 32'h103;
    tick();
    clear_strobes();
    #1;
    total++; if (redir_pend !== 1'b1 || pc !== 32'h20) $display("FAIL bb_pend got pend=%0b pc=%h want pend=1 pc=00000020", redir_pend, pc); else passed++;
    req_ready = 1;
    #1;
    total++; if (req_stale !== 1'b1) $display("FAIL bb_stale got=%0b want=1", req_stale); else passed++;
    tick();
    total++; if (pc !== 32'h100 || redir_pend !== 1'b0) $display("FAIL bb_apply got pc=%h pend=%0b want pc=00000100 pend=0", pc, redir_pend); else passed++;
    $display("buffered branch applied pc=%h", pc);
  endtask

  task test_priority();
    stall = 1; req_ready = 1;
    tick();
    exc = 1; exc_vec = 32'h200; br_taken = 1; br_target = 32'h300;
    tick();
    clear_strobes();
    total++; if (pc !== 32'h200 || req_valid !== 1'b0) $display("FAIL prio_idle got pc=%h v=%0b want pc=00000200 v=0", pc, req_valid); else passed++;
    stall = 0; req_ready = 0;
    tick();
    exc = 1; exc_vec = 32'h200;
    tick();
    clear_strobes(); br_taken = 1; br_target = 32'h300;
    tick();
    clear_strobes(); req_ready = 1;
    tick();
    total++; if (pc !== 32'h200) $display("FAIL prio_pend got=%h want=00000200", pc); else passed++;
    total++; if (pc !== m_pc) $display("FAIL prio_model got=%h want=%h", pc, m_pc); else passed++;
    $display("priority test pc=%h", pc);
  endtask

  task test_wrap_and_clk_en();
    req_ready = 0; br_taken = 1; br_target = 32'hFFFF_FFFC;
    tick();
    clear_strobes(); req_ready = 1;
    tick();
    total++; if (pc !== 32'hFFFF_FFFC || pc_plus !== 32'h0) $display("FAIL wrap_pre got pc=%h plus=%h want fffffffc/00000000", pc, pc_plus); else passed++;
    tick();
    total++; if (pc !== 32'h0) $display("FAIL wrap got=%h want=00000000", pc); else passed++;
    clk_en = 0; br_taken = 1; br_target = 32'h700; exc = 1; exc_vec = 32'h800;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (pc !== 32'h0 || redir_pend !== 1'b0 || req_valid !== 1'b1) $display("FAIL clk_en c=%0d got pc=%h pend=%0b v=%0b want 00000000/0/1", c, pc, redir_pend, req_valid); else passed++;
    end
    clk_en = 1; clear_strobes();
    $display("wrap/clk_en test pc=%h", pc);
  endtask

  task test_async_reset();
    req_ready = 0; br_taken = 1; br_target = 32'h500;
    tick();
    clear_strobes();
    total++; if (redir_pend !== 1'b1) $display("FAIL ar_pre got=%0b want=1", redir_pend); else passed++;
    rst_n = 0;
    #1;
    total++; if (req_valid !== 1'b0 || redir_pend !== 1'b0 || pc !== 32'h0) $display("FAIL ar got v=%0b pend=%0b pc=%h want 0/0/00000000", req_valid, redir_pend, pc); else passed++;
    model_reset();
    rst_n = 1;
    $display("async reset mid-request pc=%h", pc);
  endtask

  task test_random();
    bit exp_v;
    for (int c = 0; c < 400; c++) begin
      clk_en    = ($urandom_range(9) != 0);
      stall     = ($urandom_range(4) == 0);
      req_ready = ($urandom_range(9) < 6);
      br_taken  = ($urandom_range(7) == 0);
      exc       = ($urandom_range(11) == 0);
      mret      = ($urandom_range(11) == 0);
      br_target = $urandom; exc_vec = $urandom; mepc = $urandom;
      if ($urandom_range(99) == 0) begin
        rst_n = 0;
        #1;
        model_reset();
        rst_n = 1;
      end
      #1;
      exp_v = (m_mode == M_REQ);
      total++; if (req_valid !== exp_v) $display("FAIL rnd_valid c=%0d got=%0b want=%0b", c, req_valid, exp_v); else passed++;
      total++; if (pc !== m_pc || pc_plus !== m_pc + 32'd4) $display("FAIL rnd_pc c=%0d got=%h/%h want=%h", c, pc, pc_plus, m_pc); else passed++;
      total++; if (redir_pend !== m_pend) $display("FAIL rnd_pend c=%0d got=%0b want=%0b", c, redir_pend, m_pend); else passed++;
      if (exp_v && req_ready && clk_en) begin
        total++;
        if (req_stale !== (m_pend || br_taken || exc || mret))
          $display("FAIL rnd_stale c=%0d got=%0b want=%0b", c, req_stale, (m_pend || br_taken || exc || mret));
        else passed++;
      end
      $display("rnd %0d en=%0b rdy=%0b v=%0b pc=%h pend=%0b", c, clk_en, req_ready, req_valid, pc, redir_pend);
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_boot_seq();
    test_hold();
    test_buffered_branch();
    test_priority();
    test_wrap_and_clk_en();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
